serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around one instance of the existing full_adder cell (ports a, b, c, s, cout) plus a carry flip-flop. It accepts a pair of operands and a carry-in over a valid/ready handshake. It adds them LSB-first, one bit per clock, and presents the registered sum and carry-out over a second valid/ready handshake. It is the sequential consumer of full_adder and trades area for WIDTH-cycle latency.

---
 rtl/serial_adder_if.sv | 32 +++
 rtl/serial_adder.sv | 149 ++++++++++++++
 tb/tb_serial_adder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: an operand channel (a, b, cin) and a
// result channel (sum, cout).
//
// Both channels use the same valid/ready rule: a transfer happens on a rising
// clock edge where valid and ready are both 1. The producer holds its payload
// stable while valid is high and ready is low. The consumer may drive ready
// without waiting for valid.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   // Upstream/downstream environment side.
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   // Adder side.
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. A single full_adder cell and a carry flop add
// the operands LSB-first, one bit per clock. The registered {cout,sum} is
// offered on the result channel until downstream takes it.

// One-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ c;
   assign cout = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_adder_if.slave        bus,
   output logic [1:0]           o_state
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_acc_sh;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic [CW-1:0]    r_cnt;
   logic             w_s;
   logic             w_c;
   logic             w_load;
   logic             w_step;
   logic             w_last;
   logic             w_in_ready;
   logic             w_out_valid;
   logic [WIDTH-1:0] w_acc_next;

   full_adder u_fa (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .c    (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   // The new sum bit enters at the MSB, so after WIDTH steps bit 0 sits at the LSB.
   generate
      if (WIDTH == 1) begin : g_acc_w1
         assign w_acc_next = w_s;
      end else begin : g_acc_wn
         assign w_acc_next = {w_s, r_acc_sh[WIDTH-1:1]};
      end
   endgenerate

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // Next-state and handshake decode. Ready and valid come from different
   // states, so they are never high together.
   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_load = 1'b1;
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register; reset aborts any in-flight add.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Operand shifters, carry and bit counter: loaded on accept, stepped in RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_acc_sh <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
      end else if (w_load) begin
         r_a_sh  <= bus.a;
         r_b_sh  <= bus.b;
         r_carry <= bus.cin;
         r_cnt   <= '0;
      end else if (w_step) begin
         r_a_sh   <= r_a_sh >> 1;
         r_b_sh   <= r_b_sh >> 1;
         r_acc_sh <= w_acc_next;
         r_carry  <= w_c;
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   // Result registers; they change only when the final bit completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else if (w_step && w_last) begin
         r_sum  <= w_acc_next;
         r_cout <= w_c;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign o_state       = r_state;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 1 and 4. All three instances share
// clock and reset. Inputs change on the falling edge. A transaction-level
// model updates on the rising edge. One compare process checks every
// instance on each falling edge.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();
  serial_adder_if #(.WIDTH(4)) if4 ();
  logic [1:0] st8, st1, st4;

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8), .o_state(st8));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .o_state(st1));
  serial_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4), .o_state(st4));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: index 0 -> WIDTH 8, 1 -> WIDTH 1, 2 -> WIDTH 4.
  // Phase 0 = waiting for operands, 1 = adding, 2 = result offered.
  int          widths[3] = '{8, 1, 4};
  int          m_phase[3];
  int          m_left[3];
  logic [32:0] m_res[3];
  logic [32:0] m_out[3];

  task automatic model_step(input int k, input logic iv, input logic [31:0] a,
                            input logic [31:0] b, input logic cin, input logic ordy);
    logic [32:0] mask;
    mask = (33'd1 << widths[k]) - 33'd1;
    case (m_phase[k])
      0: if (iv) begin
        m_res[k]   = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 33'(cin);
        m_left[k]  = widths[k];
        m_phase[k] = 1;
      end
      1: begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_phase[k] = 2;
          m_out[k]   = m_res[k];
        end
      end
      default: if (ordy) m_phase[k] = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_phase[k] = 0;
        m_left[k]  = 0;
        m_out[k]   = '0;
      end
    end else begin
      model_step(0, if8.in_valid, 32'(if8.a), 32'(if8.b), if8.cin, if8.out_ready);
      model_step(1, if1.in_valid, 32'(if1.a), 32'(if1.b), if1.cin, if1.out_ready);
      model_step(2, if4.in_valid, 32'(if4.a), 32'(if4.b), if4.cin, if4.out_ready);
    end
  end

  function automatic logic rd_in_ready(input int k);
    case (k)
      0: return if8.in_ready;
      1: return if1.in_ready;
      default: return if4.in_ready;
    endcase
  endfunction

  function automatic logic rd_out_valid(input int k);
    case (k)
      0: return if8.out_valid;
      1: return if1.out_valid;
      default: return if4.out_valid;
    endcase
  endfunction

  function automatic logic [32:0] rd_res(input int k);
    case (k)
      0: return (33'(if8.cout) << 8) | 33'(if8.sum);
      1: return (33'(if1.cout) << 1) | 33'(if1.sum);
      default: return (33'(if4.cout) << 4) | 33'(if4.sum);
    endcase
  endfunction

  task automatic cmp(input int k);
    check($sformatf("in_ready[w%0d]", widths[k]), 33'(rd_in_ready(k)), 33'(m_phase[k] == 0));
    check($sformatf("out_valid[w%0d]", widths[k]), 33'(rd_out_valid(k)), 33'(m_phase[k] == 2));
    if (m_phase[k] == 2)
      check($sformatf("result[w%0d]", widths[k]), rd_res(k), m_out[k]);
  endtask

  // Compare process.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) cmp(k);
  end

  task automatic drive_small(input int k, input logic iv, input logic [3:0] a,
                             input logic [3:0] b, input logic cin);
    if (k == 1) begin
      if1.in_valid = iv; if1.a = a[0]; if1.b = b[0]; if1.cin = cin;
    end else begin
      if4.in_valid = iv; if4.a = a; if4.b = b; if4.cin = cin;
    end
  endtask

  task automatic set_ordy(input int k, input logic r);
    if (k == 1) if1.out_ready = r;
    else        if4.out_ready = r;
  endtask

  // One add on the WIDTH 8 instance with hand-computed result.
  // hold >= 0: hold that many cycles of backpressure with fresh operands on
  // in_valid, then hand off. hold < 0: leave the result waiting in DONE.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] es, input logic ec, input int hold);
    int t0, g;
    logic [8:0] exp;
    exp = {ec, es};
    @(negedge clk);
    if8.a = a; if8.b = b; if8.cin = cin; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    g = 0;
    while (if8.in_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    check("accept8_timeout", 33'(g >= 50), 33'd0);
    t0 = cyc;
    @(negedge clk);
    if8.in_valid = 1'b0; if8.a = ~a; if8.b = 8'h5C; if8.cin = ~cin;
    g = 0;
    while (if8.out_valid !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    check("latency8", 33'(cyc - t0 - 1), 33'd8);
    check("model_pin8", m_out[0], 33'(exp));
    check("sum8", 33'(if8.sum), 33'(es));
    check("cout8", 33'(if8.cout), 33'(ec));
    for (int i = 0; i < hold; i++) begin
      if8.in_valid = 1'b1; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
      @(negedge clk);
      check("bp_sum8", 33'(if8.sum), 33'(es));
      check("bp_cout8", 33'(if8.cout), 33'(ec));
      check("bp_valid8", 33'(if8.out_valid), 33'd1);
      check("bp_ready8", 33'(if8.in_ready), 33'd0);
    end
    if (hold >= 0) begin
      if8.in_valid = 1'b0; if8.out_ready = 1'b1;
      @(negedge clk);
      check("handoff_ready8", 33'(if8.in_ready), 33'd1);
      check("handoff_valid8", 33'(if8.out_valid), 33'd0);
      if8.out_ready = 1'b0;
    end
  endtask

  // One add on the WIDTH 1 or 4 instance, with random out_ready during handoff.
  task automatic add_small(input int k, input logic [3:0] a, input logic [3:0] b, input logic cin);
    int t0, g;
    logic r;
    logic [32:0] mask, exp;
    mask = (33'd1 << widths[k]) - 33'd1;
    exp  = (33'(a) & mask) + (33'(b) & mask) + 33'(cin);
    @(negedge clk);
    drive_small(k, 1'b1, a, b, cin);
    set_ordy(k, 1'($urandom_range(0, 1)));
    g = 0;
    while (rd_in_ready(k) !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    check("accept_timeout", 33'(g >= 50), 33'd0);
    t0 = cyc;
    @(negedge clk);
    drive_small(k, 1'b0, ~a, ~b, ~cin);
    g = 0;
    while (rd_out_valid(k) !== 1'b1 && g < 50) begin
      set_ordy(k, 1'($urandom_range(0, 1)));
      @(negedge clk);
      g++;
    end
    check($sformatf("latency[w%0d]", widths[k]), 33'(cyc - t0 - 1), 33'(widths[k]));
    check($sformatf("sum_direct[w%0d]", widths[k]), rd_res(k), exp);
    g = 0;
    do begin
      r = 1'($urandom_range(0, 1));
      set_ordy(k, r);
      @(negedge clk);
      g++;
    end while (r == 1'b0 && g < 20);
    if (r == 1'b0) begin
      set_ordy(k, 1'b1);
      @(negedge clk);
    end
    set_ordy(k, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.out_ready = 1'b0;
    #3;
    check("rst_valid8", 33'(if8.out_valid), 33'd0);
    check("rst_sum8", 33'(if8.sum), 33'd0);
    check("rst_cout8", 33'(if8.cout), 33'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready8", 33'(if8.in_ready), 33'd1);

    // Wrap-around and carry cases.
    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    add8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0);
    add8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0);
    // Backpressure with new operands presented.
    add8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 5);
    add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);

    // Asynchronous reset in the middle of a cycle while a result waits.
    add8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid8", 33'(if8.out_valid), 33'd0);
    check("midrst_sum8", 33'(if8.sum), 33'd0);
    check("midrst_cout8", 33'(if8.cout), 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready8", 33'(if8.in_ready), 33'd1);

    // Reset during the fourth RUN cycle.
    @(negedge clk);
    if8.a = 8'h77; if8.b = 8'h11; if8.cin = 1'b0; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_state8", 33'(st8), 33'd0);
    check("abort_valid8", 33'(if8.out_valid), 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_valid8", 33'(if8.out_valid), 33'd0);
    end
    add8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 0);

    // Exhaustive sweeps of the narrow instances.
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          add_small(1, 4'(a), 4'(b), 1'(c));
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          add_small(2, 4'(a), 4'(b), 1'(c));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
